// File: rtl/sb_rx_deframer_pkg.sv
// Shared constants and FSM state types for the USB4 sideband receive deframer.
package sb_rx_deframer_pkg;

  localparam logic [7:0] SB_DLE     = 8'hFE;
  localparam logic [7:0] SB_STX_CMD = 8'h05;
  localparam logic [7:0] SB_STX_RSP = 8'h04;
  localparam logic [7:0] SB_ETX     = 8'h40;

  typedef enum logic [1:0] {
    BIT_IDLE,
    BIT_DATA,
    BIT_STOP,
    BIT_BRK
  } bit_state_e;

  typedef enum logic [1:0] {
    BYTE_HUNT,
    BYTE_HUNT_DLE,
    BYTE_PKT,
    BYTE_PKT_DLE
  } byte_state_e;

  function automatic logic is_stx(input logic [7:0] b);
    return (b == SB_STX_CMD) || (b == SB_STX_RSP);
  endfunction

endpackage

// File: rtl/sb_uart_rx.sv
// Sideband line synchronizer plus 10-bit UART symbol recovery, one bit per sb_clk.
module sb_uart_rx
  import sb_rx_deframer_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       sb_clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       sbtx,
  output logic [7:0] byte_data,
  output logic       byte_done,
  output logic       frame_err
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  bit_state_e             state;
  logic [2:0]             bit_cnt;
  logic [7:0]             shreg;

  // Synchronizer presets to the idle-high line level so reset release never looks like a start bit.
  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sbtx};
    end
  end

  assign s         = sync_q[SYNC_STAGES-1];
  assign byte_data = shreg;

  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      state     <= BIT_IDLE;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      byte_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      byte_done <= 1'b0;
      frame_err <= 1'b0;
      if (!enable) begin
        state <= BIT_IDLE;
      end else begin
        case (state)
          BIT_IDLE: begin
            if (!s) begin
              state   <= BIT_DATA;
              bit_cnt <= 3'd0;
            end
          end
          BIT_DATA: begin
            shreg   <= {s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= BIT_STOP;
          end
          BIT_STOP: begin
            if (s) begin
              byte_done <= 1'b1;
              state     <= BIT_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BIT_BRK;
            end
          end
          // A stuck-low line must return high before another start bit is accepted.
          BIT_BRK: if (s) state <= BIT_IDLE;
          default: state <= BIT_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/sb_rx_deframer.sv
// USB4 sideband receive deframer: strips DLE framing/stuffing and emits a byte stream with markers.
module sb_rx_deframer
  import sb_rx_deframer_pkg::*;
#(
  parameter int MAX_LEN     = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic       sb_clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       sbtx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_sop,
  output logic       rx_type,
  output logic       rx_eop,
  output logic       frame_err,
  output logic       proto_err,
  output logic       busy
);

  localparam int              LEN_W   = $clog2(MAX_LEN + 2);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  logic [7:0]        uart_byte;
  logic              uart_done;
  logic              uart_ferr;
  byte_state_e       state;
  logic [LEN_W-1:0]  len;
  logic              len_full;

  sb_uart_rx #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_uart (
    .sb_clk   (sb_clk),
    .rst      (rst),
    .enable   (enable),
    .sbtx     (sbtx),
    .byte_data(uart_byte),
    .byte_done(uart_done),
    .frame_err(uart_ferr)
  );

  // One more payload byte would exceed MAX_LEN.
  assign len_full = (len == LEN_MAX);

  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      state     <= BYTE_HUNT;
      len       <= '0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      rx_sop    <= 1'b0;
      rx_type   <= 1'b0;
      rx_eop    <= 1'b0;
      frame_err <= 1'b0;
      proto_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      rx_sop    <= 1'b0;
      rx_eop    <= 1'b0;
      frame_err <= 1'b0;
      proto_err <= 1'b0;
      if (!enable) begin
        state <= BYTE_HUNT;
        busy  <= 1'b0;
      end else if (uart_ferr) begin
        frame_err <= 1'b1;
        if (busy) begin
          state <= BYTE_HUNT;
          busy  <= 1'b0;
        end
      end else if (uart_done) begin
        case (state)
          BYTE_HUNT: if (uart_byte == SB_DLE) state <= BYTE_HUNT_DLE;
          BYTE_HUNT_DLE: begin
            if (is_stx(uart_byte)) begin
              rx_sop  <= 1'b1;
              rx_type <= (uart_byte == SB_STX_CMD);
              busy    <= 1'b1;
              len     <= '0;
              state   <= BYTE_PKT;
            end else begin
              state <= BYTE_HUNT;
            end
          end
          BYTE_PKT: begin
            if (uart_byte == SB_DLE) begin
              state <= BYTE_PKT_DLE;
            end else if (len_full) begin
              proto_err <= 1'b1;
              busy      <= 1'b0;
              state     <= BYTE_HUNT;
            end else begin
              rx_valid <= 1'b1;
              rx_data  <= uart_byte;
              len      <= len + 1'b1;
            end
          end
          BYTE_PKT_DLE: begin
            if (uart_byte == SB_DLE) begin
              if (len_full) begin
                proto_err <= 1'b1;
                busy      <= 1'b0;
                state     <= BYTE_HUNT;
              end else begin
                rx_valid <= 1'b1;
                rx_data  <= SB_DLE;
                len      <= len + 1'b1;
                state    <= BYTE_PKT;
              end
            end else if (uart_byte == SB_ETX) begin
              rx_eop <= 1'b1;
              busy   <= 1'b0;
              state  <= BYTE_HUNT;
            end else if (is_stx(uart_byte)) begin
              // Unterminated packet followed by a fresh DLE-STX: flag it and restart.
              proto_err <= 1'b1;
              rx_sop    <= 1'b1;
              rx_type   <= (uart_byte == SB_STX_CMD);
              len       <= '0;
              state     <= BYTE_PKT;
            end else begin
              proto_err <= 1'b1;
              busy      <= 1'b0;
              state     <= BYTE_HUNT;
            end
          end
          default: state <= BYTE_HUNT;
        endcase
      end
    end
  end

endmodule

// File: doc/sb_rx_deframer.md
Name: sb_rx_deframer

Overview:
- Sideband receive path of the USB4 logical layer; sits directly downstream of the electrical-layer sideband pin (sbtx into the logical layer) and feeds the lane-initialization / transaction decoder.
- Synchronizes the serial line, recovers 10-bit UART symbols (start, 8 data LSB-first, stop) at one bit per sb_clk, strips DLE framing and DLE stuffing, and emits a byte stream with start/end markers and error pulses.

Parameters:
- MAX_LEN, 64, maximum payload bytes between DLE-STX and DLE-ETX; exceeding it aborts the transaction.
- SYNC_STAGES, 2, input synchronizer depth (allowed values 2..3).

Ports:
- sb_clk  input  1  sideband clock, one bit period per cycle.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  0 holds both FSMs in idle and drops any partial transaction silently.
- sbtx  input  1  serial sideband line; idles high.
- rx_data  output  8  de-stuffed payload byte.
- rx_valid  output  1  one-cycle strobe; rx_data is valid.
- rx_sop  output  1  one-cycle strobe on DLE-STX; rx_type is valid in the same cycle.
- rx_type  output  1  1 = command (STX 8'h05), 0 = response (STX 8'h04).
- rx_eop  output  1  one-cycle strobe on DLE-ETX, with rx_valid=0.
- frame_err  output  1  one-cycle strobe: stop bit sampled low.
- proto_err  output  1  one-cycle strobe: illegal byte after DLE, or MAX_LEN exceeded.
- busy  output  1  high while a transaction is open, from DLE-STX through DLE-ETX or abort.

Behaviour:
- Reset:
  - All outputs are 0; rx_data is 8'h00.
  - Synchronizer flops reset to 1 (line idle).
  - Both FSMs reset to their idle states.
- Bit FSM (operates on the synchronized line s):
  - IDLE: s==0 -> DATA, bit_cnt=0.
  - DATA: shift s into bit 7 of shreg, so the LSB arrives first. bit_cnt increments each cycle; after 8 bits -> STOP.
  - STOP:
    - s==1: byte_done pulses in the next cycle -> IDLE.
    - s==0: frame_err pulses -> BRK.
  - BRK: wait for s==1 -> IDLE. This prevents a stuck-low line from decoding as 8'h00 bytes.
  - A new start bit may be sampled in the cycle immediately after STOP, giving back-to-back 10-cycle symbols.
- Latency: stop bit sampled at synchronized cycle N -> byte_done at N+1 -> rx_valid / rx_sop / rx_eop at N+2. Pin-to-output latency is SYNC_STAGES+2 cycles after the stop-bit edge.
- Byte FSM (advances only on byte_done):
  - HUNT: 8'hFE -> HUNT_DLE; anything else is discarded with no error.
  - HUNT_DLE:
    - 8'h05 / 8'h04: rx_sop, set rx_type, busy=1, len=0 -> PKT.
    - Otherwise -> HUNT with no error.
  - PKT:
    - 8'hFE -> PKT_DLE.
    - Otherwise emit the byte: rx_valid, len++.
  - PKT_DLE:
    - 8'hFE: emit literal 8'hFE, len++ -> PKT.
    - 8'h40: rx_eop, busy=0 -> HUNT.
    - 8'h05 / 8'h04: proto_err, then treat as a new DLE-STX. rx_sop is in the same cycle as proto_err -> PKT.
    - Any other byte: proto_err, busy=0 -> HUNT.
  - Length limit: an emit that would make len == MAX_LEN+1 is suppressed; proto_err pulses, busy=0 -> HUNT.
  - len counter width is $clog2(MAX_LEN+2).
- frame_err inside a transaction also aborts it: busy=0 and the byte FSM -> HUNT. A frame error outside a transaction leaves the byte FSM unchanged.
- enable deasserted:
  - Both FSMs are forced to idle on the next edge and busy=0.
  - No strobes are generated while enable==0.
  - Decoding resumes only on a fresh start bit.
- rst asserted mid-transaction clears everything immediately. No strobes are generated after reset release until a complete symbol is received.
- Strobe exclusivity:
  - rx_valid, rx_sop and rx_eop are mutually exclusive.
  - proto_err may coincide with rx_sop (restart case only).

Decomposition:
- tb_pkg-side shared package holds the constants SB_DLE=8'hFE, SB_STX_CMD=8'h05, SB_STX_RSP=8'h04, SB_ETX=8'h40, and the enums for the bit FSM and byte FSM states.
- One sub-module is natural: sb_uart_rx (synchronizer plus bit FSM, outputs byte and byte_done / frame_err).
- sb_rx_deframer instantiates it and implements the byte FSM.

Test Plan:
- Command transaction:
  - Stimulus: DLE,05,11,22,DLE,40 sent back-to-back.
  - Response: rx_sop with rx_type=1, rx_valid with 8'h11 then 8'h22, rx_eop; busy is high from sop through eop; rx_valid occurs SYNC_STAGES+2 cycles after each stop-bit edge.
- Stuffing:
  - Stimulus: DLE,04,FE,FE,33,DLE,40.
  - Response: rx_type=0; payload 8'hFE, 8'h33; no errors.
- Frame error:
  - Stimulus: 10 (stop bit forced 0) mid-packet, line held low 20 cycles, then DLE,05,AA,DLE,40.
  - Response: frame_err once, busy drops; no bytes emitted during the low period; the second packet decodes with payload 8'hAA.
- Overflow:
  - Stimulus: MAX_LEN=4, payload 01..05.
  - Response: rx_valid four times (01..04), proto_err on the 5th byte, busy=0; the trailing DLE,40 produces no rx_eop.
- Bad DLE:
  - Stimulus: DLE,05,DLE,77.
  - Response: proto_err, busy=0.
  - Restart case: DLE,05,DLE,04 gives proto_err together with rx_sop, rx_type=0.
- Reset / enable:
  - Stimulus: rst low for 3 cycles mid-byte, then a clean packet.
  - Response: all outputs are 0 during reset and the packet then decodes correctly.
  - Stimulus: enable=0 during a packet.
  - Response: no strobes are generated.
